uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver that consumes the 16x-oversampling baud tick produced by the tick generator.
- Samples the serial line at mid-bit and deserialises LSB-first frames: 1 start, DATA_BITS data, 1 stop.
- Presents each received byte with a one-cycle done strobe to downstream logic (Rx FIFO / interface unit).

Parameters:
- DATA_BITS, 8, number of data bits per frame.
- STOP_TICKS, 16, oversampling ticks spanning the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_rx  input  1  serial line, idle high, asynchronous to i_clk.
- i_tick  input  1  16x baud enable; 1-cycle pulse from the tick generator.
- o_data  output  DATA_BITS  last received word; held until the next frame completes.
- o_rx_done  output  1  1-cycle pulse when a frame completes.
- o_frame_err  output  1  stop bit sampled low on the last frame; updated together with o_rx_done.

Behaviour:
- Clock and reset: one clock (i_clk). Reset is asynchronous and active-high (i_rst).
- Reset values:
  - state = IDLE; tick counter s = 0; bit counter n = 0; shift register = 0.
  - o_data = 0, o_rx_done = 0, o_frame_err = 0.
  - Both synchroniser flops = 1, so the line reads idle.
- Input sync: i_rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s, which adds 2 i_clk of latency.
- State advance: the FSM changes state only on cycles where i_tick = 1, except IDLE start detection, which is evaluated every i_clk. Counters s (4 bits, or wide enough for STOP_TICKS-1) and n advance only on i_tick.
- IDLE:
  - rx_s == 0 → START with s = 0.
  - Otherwise stay in IDLE.
- START (on each tick):
  - If s == 7, sample rx_s:
    - 0 → DATA with s = 0, n = 0.
    - 1 → IDLE (glitch reject; no done pulse, no output change).
  - Else s = s + 1.
- DATA (on each tick):
  - If s == 15: s = 0; shift rx_s into the MSB of the shift register (right shift, so the first bit ends in the LSB).
    - If n == DATA_BITS-1 → STOP.
    - Else n = n + 1.
  - Else s = s + 1.
- STOP (on each tick):
  - If s == STOP_TICKS-1:
    - o_data ← shift register.
    - o_frame_err ← ~rx_s.
    - o_rx_done = 1 for exactly one i_clk.
    - → IDLE, s = 0.
  - Else s = s + 1.
- Sample points: every sample falls at mid-bit (8 ticks after the detected falling edge, then every 16 ticks).
- Latency: o_rx_done rises 1 i_clk after the tick that samples the stop bit.
- A frame with a bad stop bit is still delivered: o_data updated, o_frame_err = 1.
- Tick stall: if i_tick stays low, the FSM holds state and counters indefinitely. There is no timeout.
- Back-to-back frames: from IDLE, a start bit beginning immediately after the stop sample is detected normally.
- Reset mid-frame: aborts instantly to IDLE with all outputs zero. The next start edge is received normally.
- o_rx_done is never asserted more than one consecutive cycle.
- o_data and o_frame_err change only in the cycle o_rx_done asserts.

Test Plan:
- Bench setup: drive i_tick as a 1-cycle pulse every 4 i_clk, so one bit = 64 i_clk.
- Frame 0x55, valid stop → exactly one o_rx_done pulse; o_data = 0x55; o_frame_err = 0.
- Frames 0xA3 then 0x0F back-to-back (no idle gap) → two done pulses in order; o_data = 0xA3, then 0x0F; o_frame_err = 0 both.
- Start glitch: rx low for 3 ticks (12 i_clk), then high → no o_rx_done; FSM returns to IDLE. A following 0x3C frame is received correctly.
- Frame 0xFF with stop bit driven 0 → o_rx_done pulses; o_data = 0xFF; o_frame_err = 1. A following good 0x01 frame clears o_frame_err to 0.
- Reset mid-frame (assert i_rst asynchronously during data bit 4 of 0x81) → o_data, o_rx_done and o_frame_err go to 0 without waiting for a clock. A subsequent 0x7E frame yields o_data = 0x7E.
- Tick stall: hold i_tick = 0 for 500 i_clk mid-frame, then resume → frame 0xC6 is still received correctly. No done pulse occurs during the stall.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, LSB-first frames (1 start, DATA_BITS data, 1 stop).
// Each completed frame is presented on o_data with a one-cycle o_rx_done strobe.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_tick,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err
);

  localparam int S_W = (STOP_TICKS > 16) ? $clog2(STOP_TICKS) : 4;
  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [S_W-1:0] S_MID      = S_W'(7);
  localparam logic [S_W-1:0] S_BIT_END  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_END = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST     = N_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic [S_W-1:0]       s;
  logic [N_W-1:0]       n;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic                 rx_meta;
  logic                 rx_s;

  // Both flops reset high so the line reads idle straight out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Right shift: the first data bit received ends up in the LSB.
  // NOTE: always_comb outputs get a default first so no path can infer a latch.
  always_comb begin
    shift_next = shift;
    shift_next = DATA_BITS'({rx_s, shift} >> 1);
  end

  // Start detection runs every clock; all other progress is gated by i_tick.
  // NOTE: the shift register is reset too; it is small datapath state, and a
  // defined value keeps o_data deterministic in simulation and in silicon.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      s           <= '0;
      n           <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end

        START: begin
          if (i_tick) begin
            if (s == S_MID) begin
              s <= '0;
              if (!rx_s) begin
                state <= DATA;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + S_W'(1);
            end
          end
        end

        DATA: begin
          if (i_tick) begin
            if (s == S_BIT_END) begin
              s     <= '0;
              shift <= shift_next;
              if (n == N_LAST) begin
                state <= STOP;
              end else begin
                n <= n + N_W'(1);
              end
            end else begin
              s <= s + S_W'(1);
            end
          end
        end

        STOP: begin
          if (i_tick) begin
            if (s == S_STOP_END) begin
              o_data      <= shift;
              o_frame_err <= ~rx_s;
              o_rx_done   <= 1'b1;
              state       <= IDLE;
              s           <= '0;
            end else begin
              s <= s + S_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
